// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that merges NUM_REQ requesters into one sync_fifo write port.
// An owner holds the grant for up to MAX_BURST accepted words, or until it drops its request.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        ack_o,
  input  logic                      fifo_full_i,
  output logic                      fifo_wr_en_o,
  output logic [DATA_W-1:0]         fifo_data_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] RESET_OWNER = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [CNT_W-1:0]   r_beat_cnt, w_beat_nxt;
  logic [IDX_W-1:0]   r_last_owner, w_last_nxt;

  logic               w_win_found;
  logic [IDX_W-1:0]   w_win_idx;
  logic [IDX_W-1:0]   w_cand;
  logic               w_owner_req;
  logic               w_owner_ack;
  logic               w_release;
  logic [NUM_REQ-1:0] w_ack;
  logic [DATA_W-1:0]  w_data;

  // State register. r_last_owner is the current owner while BUSY and the
  // previous owner while IDLE, so one register serves both purposes.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_beat_cnt   <= '0;
      r_last_owner <= RESET_OWNER;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_beat_cnt   <= w_beat_nxt;
      r_last_owner <= w_last_nxt;
    end
  end

  // Round-robin search from last_owner+1; last_owner itself is tried last.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(r_last_owner) + i) % NUM_REQ);
      if (!w_win_found && req_i[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  assign w_owner_req = |(r_gnt & req_i);
  assign w_owner_ack = |w_ack;
  assign w_release   = (r_state == ST_BUSY) &&
                       (!w_owner_req || (w_owner_ack && (r_beat_cnt == LAST_BEAT)));

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_beat_nxt  = r_beat_cnt;
    w_last_nxt  = r_last_owner;
    if ((r_state == ST_IDLE) || w_release) begin
      if (w_win_found) begin
        w_state_nxt            = ST_BUSY;
        w_gnt_nxt              = '0;
        w_gnt_nxt[w_win_idx]   = 1'b1;
        w_beat_nxt             = '0;
        w_last_nxt             = w_win_idx;
      end else begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_beat_nxt  = '0;
      end
    end else if (w_owner_ack) begin
      w_beat_nxt = r_beat_cnt + 1'b1;
    end
  end

  // Output logic: zero-latency acceptance, data muxed from the owner's slice.
  always_comb begin
    w_ack  = r_gnt & req_i & {NUM_REQ{~fifo_full_i}};
    w_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_gnt[k]) w_data = w_data | data_i[k*DATA_W +: DATA_W];
    end
  end

  assign gnt_o        = r_gnt;
  assign ack_o        = w_ack;
  assign fifo_wr_en_o = |w_ack;
  assign fifo_data_o  = w_data;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table plus hand-written
// sequences for async reset and an 8-deep FIFO fill/drain.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_i = '0;
  logic [31:0] data_i = '0;
  logic [3:0]  gnt_o;
  logic [3:0]  ack_o;
  logic        fifo_full_i = 1'b0;
  logic        fifo_wr_en_o;
  logic [7:0]  fifo_data_o;

  int n_checks = 0;
  int n_errors = 0;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .data_i       (data_i),
    .gnt_o        (gnt_o),
    .ack_o        (ack_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_data_o  (fifo_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic [3:0] ack;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] TBL_DATA = 32'h44332211;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input bit rst, input logic [3:0] req, input logic full,
                              input logic [3:0] gnt, input logic [3:0] ack);
    vec_t v;
    v.rst = rst; v.req = req; v.full = full; v.gnt = gnt; v.ack = ack;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] owner_data(input logic [3:0] g);
    case (g)
      4'b0001: return 8'h11;
      4'b0010: return 8'h22;
      4'b0100: return 8'h33;
      4'b1000: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] fifo_byte(input int k, input int j);
    logic [3:0] hi, lo;
    hi = 4'(k + 1);
    lo = 4'(j);
    return {hi, lo};
  endfunction

  // Leaves the bench at posedge+1 with rst_n released, state IDLE.
  task automatic do_reset();
    rst_n       = 1'b0;
    req_i       = '0;
    fifo_full_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Four requesters held: grants 0,1,2,3,0, four acks each, no idle cycles.
    add(1, 4'b1111, 0, 4'b0000, 4'b0000);
    for (int o = 0; o < 5; o++)
      for (int b = 0; b < 4; b++)
        add(0, 4'b1111, 0, 4'(1 << (o % 4)), 4'(1 << (o % 4)));
    // Lone requester 2: re-granted after acks 4 and 8, idle after req drops.
    add(1, 4'b0100, 0, 4'b0000, 4'b0000);
    for (int b = 0; b < 10; b++) add(0, 4'b0100, 0, 4'b0100, 4'b0100);
    add(0, 4'b0000, 0, 4'b0100, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000);
    // Owner 1 stalls 3 cycles on full; burst still ends after 4 acks.
    add(1, 4'b0010, 0, 4'b0000, 4'b0000);
    add(0, 4'b0011, 0, 4'b0010, 4'b0010);
    add(0, 4'b0011, 0, 4'b0010, 4'b0010);
    for (int b = 0; b < 3; b++) add(0, 4'b0011, 1, 4'b0010, 4'b0000);
    add(0, 4'b0011, 0, 4'b0010, 4'b0010);
    add(0, 4'b0011, 0, 4'b0010, 4'b0010);
    add(0, 4'b0011, 0, 4'b0001, 4'b0001);
    // Owner 0 drops after 2 acks with requester 3 waiting; no preemption before.
    add(1, 4'b0001, 0, 4'b0000, 4'b0000);
    add(0, 4'b1001, 0, 4'b0001, 4'b0001);
    add(0, 4'b1001, 0, 4'b0001, 4'b0001);
    add(0, 4'b1000, 0, 4'b0001, 4'b0000);
    add(0, 4'b1000, 0, 4'b1000, 4'b1000);

    data_i = TBL_DATA;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      req_i       = vecs[i].req;
      fifo_full_i = vecs[i].full;
      #1;
      check($sformatf("v%0d gnt", i),   32'(gnt_o),        32'(vecs[i].gnt));
      check($sformatf("v%0d ack", i),   32'(ack_o),        32'(vecs[i].ack));
      check($sformatf("v%0d wr_en", i), 32'(fifo_wr_en_o), 32'(|vecs[i].ack));
      check($sformatf("v%0d data", i),  32'(fifo_data_o),  32'(owner_data(vecs[i].gnt)));
      @(posedge clk);
      #1;
    end

    // Async reset mid-burst of requester 2, then release with req 0101.
    do_reset();
    req_i = 4'b0100;
    @(posedge clk); #1;
    check("rst seq gnt before", 32'(gnt_o), 32'h4);
    check("rst seq ack before", 32'(ack_o), 32'h4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst async gnt",   32'(gnt_o),        32'h0);
    check("rst async ack",   32'(ack_o),        32'h0);
    check("rst async wr_en", 32'(fifo_wr_en_o), 32'h0);
    check("rst async data",  32'(fifo_data_o),  32'h0);
    @(posedge clk); #1;
    check("rst held gnt",   32'(gnt_o),        32'h0);
    check("rst held wr_en", 32'(fifo_wr_en_o), 32'h0);
    req_i = 4'b0101;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post rst gnt",  32'(gnt_o),       32'h1);
    check("post rst ack",  32'(ack_o),       32'h1);
    check("post rst data", 32'(fifo_data_o), 32'h11);

    // Three requesters write 4 bytes each into an 8-deep FIFO model.
    begin
      logic [7:0] q[$];
      int sent[3];
      int rd_cnt[3];
      int n_read;
      bit done;
      logic       w;
      logic [7:0] d;
      logic [3:0] a;
      bit rd;
      n_read = 0;
      done   = 1'b0;
      for (int k = 0; k < 3; k++) begin sent[k] = 0; rd_cnt[k] = 0; end
      do_reset();
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
        fifo_full_i = (q.size() == 8);
        req_i       = '0;
        data_i      = '0;
        for (int k = 0; k < 3; k++) begin
          if (sent[k] < 4) begin
            req_i[k] = 1'b1;
            data_i[k*8 +: 8] = fifo_byte(k, sent[k]);
          end
        end
        rd = (q.size() > 0) &&
             (((cyc % 2 == 1) && cyc >= 12) || (sent[0] + sent[1] + sent[2] == 12));
        #1;
        if (fifo_full_i) check("no wr while full", 32'(fifo_wr_en_o), 32'h0);
        w = fifo_wr_en_o;
        d = fifo_data_o;
        a = ack_o;
        if (rd) begin
          logic [7:0] b;
          int src;
          b   = q.pop_front();
          src = int'(b[7:4]) - 1;
          if (src < 0 || src > 2) begin
            check("fifo byte source", 32'(b), 32'h0);
          end else begin
            check($sformatf("order rq%0d", src), 32'(b[3:0]), 32'(rd_cnt[src]));
            rd_cnt[src]++;
          end
          n_read++;
        end
        if (w && q.size() < 8) q.push_back(d);
        for (int k = 0; k < 3; k++) if (a[k]) sent[k]++;
        if (sent[0] + sent[1] + sent[2] == 12 && q.size() == 0) done = 1'b1;
        @(posedge clk); #1;
      end
      check("fifo run completed", 32'(done), 32'h1);
      check("fifo bytes read", 32'(n_read), 32'd12);
      for (int k = 0; k < 3; k++)
        check($sformatf("fifo rq%0d count", k), 32'(rd_cnt[k]), 32'd4);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
